alu_issue: RTL and testbench

Issue and writeback stage directly upstream of the ALU. Accepts one instruction word per cycle over a valid/ready handshake and reads operands from a 16×32 register file it owns. It presents opcode and operands to the combinational ALU from a registered EX latch, and returns the ALU result through a valid/ready result port. The register file is written on result acceptance, with a bypass that resolves back-to-back dependencies without stalls.

---
 rtl/alu_issue_if.sv | 31 +++
 rtl/alu_issue.sv | 129 ++++++++++++
 tb/tb_alu_issue.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_if.sv
// Instruction and result handshake bundle between the issue stage and its neighbours.
// master = upstream/downstream environment, slave = alu_issue.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_rd;
    logic [31:0] out_data;

    modport master (
        output in_valid,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_rd,
        input  out_data
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_rd,
        output out_data
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage in front of a combinational ALU: owns a 16x32 register file,
// holds one instruction in an EX latch and writes the result back on acceptance.
module alu_issue #(
    parameter int IMM_W = 12
) (
    input  logic        clock,
    input  logic        reset,
    alu_issue_if.slave  bus,
    output logic [3:0]  alu_opcode,
    output logic [31:0] alu_reg1,
    output logic [31:0] alu_reg2,
    input  logic [31:0] alu_out,
    output logic        div0,
    input  logic [3:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    localparam logic [3:0] OP_DIV = 4'b0011;

    logic        ex_valid_reg;
    logic [3:0]  ex_op_reg;
    logic [3:0]  ex_rd_reg;
    logic [31:0] ex_a_reg;
    logic [31:0] ex_b_reg;
    logic        div0_reg;
    logic [31:0] rf_reg [16];

    logic        accept;
    logic        wb;
    logic        div_by_zero;
    logic [31:0] result;
    logic [15:0] we;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic        use_imm;
    logic [31:0] imm_ext;
    logic [31:0] op_a_next;
    logic [31:0] op_b_next;

    function automatic logic [31:0] rf_read(input logic [3:0] addr);
        return (addr == 4'd0) ? 32'd0 : rf_reg[addr];
    endfunction

    assign rs1     = bus.in_instr[23:20];
    assign rs2     = bus.in_instr[19:16];
    assign use_imm = bus.in_instr[15];
    assign imm_ext = {{(32 - IMM_W){bus.in_instr[IMM_W-1]}}, bus.in_instr[IMM_W-1:0]};

    generate
        if (IMM_W < 15) begin : g_imm_gap
            logic unused_imm_bits;
            assign unused_imm_bits = ^bus.in_instr[14:IMM_W];
        end
    endgenerate

    assign bus.in_ready = !ex_valid_reg || bus.out_ready;
    assign accept       = bus.in_valid && bus.in_ready;
    assign wb           = ex_valid_reg && bus.out_ready;

    assign div_by_zero  = (ex_op_reg == OP_DIV) && (ex_b_reg == 32'd0);
    assign result       = div_by_zero ? 32'hFFFF_FFFF : alu_out;

    assign alu_opcode   = ex_op_reg;
    assign alu_reg1     = ex_a_reg;
    assign alu_reg2     = ex_b_reg;
    assign bus.out_valid = ex_valid_reg;
    assign bus.out_rd    = ex_rd_reg;
    assign bus.out_data  = result;
    assign div0          = div0_reg;
    assign dbg_data      = rf_read(dbg_addr);

    // Bypass: the result being written this edge is newer than the regfile copy.
    always_comb begin
        op_a_next = rf_read(rs1);
        op_b_next = use_imm ? imm_ext : rf_read(rs2);
        if (wb && (ex_rd_reg != 4'd0)) begin
            if (rs1 == ex_rd_reg)
                op_a_next = result;
            if (!use_imm && (rs2 == ex_rd_reg))
                op_b_next = result;
        end
    end

    // r0 never gets a write enable, so it stays at its reset value of zero.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_we
            if (gi == 0) begin : g_r0
                assign we[gi] = 1'b0;
            end else begin : g_rn
                assign we[gi] = wb && (ex_rd_reg == 4'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++)
                rf_reg[i] <= 32'd0;
        end else begin
            for (int i = 0; i < 16; i++)
                if (we[i])
                    rf_reg[i] <= result;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ex_valid_reg <= 1'b0;
            ex_op_reg    <= 4'd0;
            ex_rd_reg    <= 4'd0;
            ex_a_reg     <= 32'd0;
            ex_b_reg     <= 32'd0;
        end else if (bus.in_ready) begin
            ex_valid_reg <= accept;
            if (accept) begin
                ex_op_reg <= bus.in_instr[31:28];
                ex_rd_reg <= bus.in_instr[27:24];
                ex_a_reg  <= op_a_next;
                ex_b_reg  <= op_b_next;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            div0_reg <= 1'b0;
        else if (wb && div_by_zero)
            div0_reg <= 1'b1;
    end
endmodule

// File: tb/tb_alu_issue.sv
// Directed plus randomized bench for alu_issue; a sequential architectural model
// predicts every result, the committed regfile and the sticky div0 flag.
module tb_alu_issue;
    localparam int IMM_W = 12;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] alu_out;
    logic [3:0]  alu_opcode;
    logic [31:0] alu_reg1;
    logic [31:0] alu_reg2;
    logic        div0;
    logic [3:0]  dbg_addr = 4'd0;
    logic [31:0] dbg_data;

    alu_issue_if bus ();

    alu_issue #(.IMM_W(IMM_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .alu_opcode (alu_opcode),
        .alu_reg1   (alu_reg1),
        .alu_reg2   (alu_reg2),
        .alu_out    (alu_out),
        .div0       (div0),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clock = ~clock;

    // Stand-in ALU; the stage must pass every opcode through untouched.
    function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return (b == 32'd0) ? 32'd0 : a / b;
            4'd4:    return a | b;
            4'd5:    return a ^ b;
            4'd6:    return a << b[4:0];
            4'd7:    return a >> b[4:0];
            default: return a + (b ^ {28'd0, op});
        endcase
    endfunction

    assign alu_out = alu_f(alu_opcode, alu_reg1, alu_reg2);

    typedef struct {
        logic [3:0]  op;
        logic [3:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        bit          dz;
    } ex_t;

    ex_t         pend[$];
    logic [31:0] arch [16];
    logic [31:0] comm [16];
    bit          div0_exp;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mk(input int op, input int rd, input int rs1, input int rs2,
                                       input int ui, input int imm);
        return {4'(op), 4'(rd), 4'(rs1), 4'(rs2), 1'(ui), 3'b000, 12'(imm)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        pend.delete();
        for (int i = 0; i < 16; i++) begin
            arch[i] = 32'd0;
            comm[i] = 32'd0;
        end
        div0_exp = 1'b0;
    endtask

    // Issue in program order: each instruction sees all earlier results.
    task automatic model_issue(input logic [31:0] ins);
        ex_t e;
        e.op = ins[31:28];
        e.rd = ins[27:24];
        e.a  = arch[ins[23:20]];
        e.b  = ins[15] ? {{(32 - IMM_W){ins[IMM_W-1]}}, ins[IMM_W-1:0]} : arch[ins[19:16]];
        e.dz = (e.op == 4'd3) && (e.b == 32'd0);
        e.res = e.dz ? 32'hFFFF_FFFF : alu_f(e.op, e.a, e.b);
        if (e.rd != 4'd0)
            arch[e.rd] = e.res;
        pend.push_back(e);
    endtask

    // One clock: called at posedge+1, samples at the falling edge, returns at posedge+1.
    task automatic cycle(input bit v, input logic [31:0] ins, input bit rdy, input logic [3:0] da);
        bit exp_rdy;
        bit acc;
        bit wbk;
        ex_t e;
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.out_ready = rdy;
        dbg_addr      = da;
        #4;
        exp_rdy = (pend.size() == 0) || rdy;
        chk("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
        chk("out_valid", 32'(bus.out_valid), 32'(pend.size() != 0));
        if (pend.size() != 0) begin
            chk("out_rd", 32'(bus.out_rd), 32'(pend[0].rd));
            chk("out_data", bus.out_data, pend[0].res);
            chk("alu_opcode", 32'(alu_opcode), 32'(pend[0].op));
            chk("alu_reg1", alu_reg1, pend[0].a);
            chk("alu_reg2", alu_reg2, pend[0].b);
        end
        chk("div0", 32'(div0), 32'(div0_exp));
        chk("dbg_data", dbg_data, comm[da]);
        acc = v && exp_rdy;
        wbk = (pend.size() != 0) && rdy;
        @(posedge clock);
        #1;
        if (wbk) begin
            e = pend.pop_front();
            if (e.rd != 4'd0)
                comm[e.rd] = e.res;
            if (e.dz)
                div0_exp = 1'b1;
            $display("wb rd=%0d op=%0d a=%h b=%h data=%h", e.rd, e.op, e.a, e.b, e.res);
        end
        if (acc)
            model_issue(ins);
    endtask

    // Asynchronous reset pulse, checked while still asserted.
    task automatic do_reset();
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b1;
        reset = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_div0", 32'(div0), 32'd0);
        chk("rst_out_rd", 32'(bus.out_rd), 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        chk("rst_alu_reg1", alu_reg1, 32'd0);
        chk("rst_alu_reg2", alu_reg2, 32'd0);
        for (int i = 0; i < 16; i++) begin
            dbg_addr = 4'(i);
            #1;
            chk("rst_dbg", dbg_data, 32'd0);
        end
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        model_clear();
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b1;
        model_clear();
        do_reset();

        // ADDI r1 = r0 + 5
        cycle(1, mk(0, 1, 0, 0, 1, 5), 1, 0);
        chk("addi_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_rd", 32'(bus.out_rd), 32'd1);
        chk("addi_data", bus.out_data, 32'd5);
        cycle(0, 0, 1, 1);
        chk("addi_dbg_r1", dbg_data, 32'd5);

        // Back-to-back dependency through the bypass
        cycle(1, mk(0, 1, 0, 0, 1, 5), 1, 0);
        cycle(1, mk(0, 2, 1, 1, 0, 0), 1, 0);
        chk("byp_rd", 32'(bus.out_rd), 32'd2);
        chk("byp_data", bus.out_data, 32'd10);
        cycle(0, 0, 1, 2);
        chk("byp_dbg_r2", dbg_data, 32'd10);

        // Backpressure for three cycles, then release
        cycle(1, mk(0, 6, 0, 0, 1, 3), 1, 0);
        repeat (3) begin
            cycle(1, mk(0, 7, 6, 0, 1, 1), 0, 6);
            chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_out_rd", 32'(bus.out_rd), 32'd6);
            chk("bp_out_data", bus.out_data, 32'd3);
            chk("bp_dbg_r6", dbg_data, 32'd0);
        end
        cycle(1, mk(0, 7, 6, 0, 1, 1), 1, 6);
        chk("bp_rel_rd", 32'(bus.out_rd), 32'd7);
        chk("bp_rel_data", bus.out_data, 32'd4);
        chk("bp_rel_dbg_r6", dbg_data, 32'd3);
        cycle(0, 0, 1, 7);
        chk("bp_dbg_r7", dbg_data, 32'd4);

        // Divide by zero and the sticky flag
        cycle(1, mk(0, 3, 0, 0, 1, 7), 1, 0);
        cycle(1, mk(3, 4, 3, 0, 0, 0), 1, 0);
        chk("div_data", bus.out_data, 32'hFFFF_FFFF);
        chk("div0_early", 32'(div0), 32'd0);
        cycle(0, 0, 1, 4);
        chk("div0_set", 32'(div0), 32'd1);
        chk("div_dbg_r4", dbg_data, 32'hFFFF_FFFF);
        cycle(1, mk(0, 8, 0, 0, 1, 1), 1, 0);
        cycle(0, 0, 1, 0);
        chk("div0_sticky", 32'(div0), 32'd1);

        // Sign extension and writes to r0
        cycle(1, mk(1, 5, 0, 0, 1, 12'hFFF), 1, 0);
        chk("subi_data", bus.out_data, 32'd1);
        cycle(1, mk(0, 0, 0, 0, 1, 9), 1, 0);
        chk("r0w_valid", 32'(bus.out_valid), 32'd1);
        chk("r0w_rd", 32'(bus.out_rd), 32'd0);
        chk("r0w_data", bus.out_data, 32'd9);
        cycle(0, 0, 1, 0);
        chk("r0_dbg", dbg_data, 32'd0);

        // Reset with an instruction stalled in EX
        cycle(1, mk(0, 9, 0, 0, 1, 2), 0, 0);
        do_reset();

        // Randomized traffic with one mid-stream reset
        for (int k = 0; k < 400; k++) begin
            logic [31:0] ins;
            if (k == 200)
                do_reset();
            ins = $urandom;
            if ($urandom_range(0, 7) == 0)
                ins = mk(3, $urandom_range(0, 15), $urandom_range(0, 15), 0, 0, 0);
            cycle($urandom_range(0, 3) != 0, ins, $urandom_range(0, 3) != 0,
                  4'($urandom_range(0, 15)));
        end
        repeat (2) cycle(0, 0, 1, 0);
        for (int i = 0; i < 16; i++)
            cycle(0, 0, 1, 4'(i));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
